// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch prefetch queue.
//   DataSizeDef : default instruction word width
//   MemSizeDef  : default PC / instruction-memory word-address width
//   QDepthDef   : default prefetch queue depth (power of two, >= 2)
//   fetch_state_e : fetch FSM state encoding
package ifetch_pkg;

    localparam int unsigned DataSizeDef = 32;
    localparam int unsigned MemSizeDef  = 10;
    localparam int unsigned QDepthDef   = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StFull  = 2'd2,
        StFlush = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ifetch_fifo.sv
// Circular FIFO holding prefetched {pc, instruction} entries.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write an entry (ignored when full)
//   pop_i         : drop the head entry (ignored when empty)
//   flush_i       : discard all entries; overrides push and pop
//   data_o        : head entry (stale when empty)
//   full_o, empty_o, count_o : occupancy status
module ifetch_fifo #(
    parameter int unsigned Width = 42,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [Width-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    // Storage needs no reset; occupancy gates every read of it.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: issues sequential IM reads, buffers responses
// with their addresses and hands them to the decoder in order. A redirect
// squashes everything queued or in flight and restarts fetch at the target.
// Optional feature macro: IFETCH_PERF_EN adds stall_count, a saturating
// count of non-idle cycles with no instruction available.
// Ports:
//   clk, reset (async active-low)
//   IM_read/IM_write/IM_enable/IM_address : instruction-memory request
//   instruction   : IM data, valid one cycle after IM_read
//   ir_valid/ir/PC, ir_ready : head instruction handshake to decoder
//   redirect_valid/redirect_pc : branch/jump redirect
//   stall_count   : (IFETCH_PERF_EN only) stall cycle counter
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int unsigned DataSize = DataSizeDef,
    parameter int unsigned MemSize  = MemSizeDef,
    parameter int unsigned QDepth   = QDepthDef
) (
`ifdef IFETCH_PERF_EN
    output logic [15:0]         stall_count,
`endif
    input  logic                clk,
    input  logic                reset,
    output logic                IM_read,
    output logic                IM_write,
    output logic                IM_enable,
    output logic [MemSize-1:0]  IM_address,
    input  logic [DataSize-1:0] instruction,
    output logic                ir_valid,
    output logic [DataSize-1:0] ir,
    output logic [MemSize-1:0]  PC,
    input  logic                ir_ready,
    input  logic                redirect_valid,
    input  logic [MemSize-1:0]  redirect_pc
);

    localparam int unsigned CntW   = $clog2(QDepth) + 1;
    localparam int unsigned EntryW = MemSize + DataSize;

    fetch_state_e         state_q;
    logic [MemSize-1:0]   fetch_addr_q;
    logic [MemSize-1:0]   resp_addr_q;  // issue address of the in-flight read
    logic                 inflight_q;
    logic                 squash_q;
    logic [EntryW-1:0]    last_q;       // last head shown, held while empty

    logic [EntryW-1:0]    head;
    logic                 fifo_full, fifo_empty;
    logic [CntW-1:0]      fifo_count;
    logic [CntW-1:0]      occupancy;
    logic                 has_space, push, pop;

    // In-flight reads count against capacity so responses never overflow.
    assign occupancy = fifo_count + CntW'(inflight_q);
    assign has_space = !fifo_full && (occupancy < CntW'(QDepth));

    assign IM_read    = (state_q == StFetch) && has_space;
    assign IM_enable  = IM_read;
    assign IM_write   = 1'b0;
    assign IM_address = fetch_addr_q;

    assign ir_valid = !fifo_empty;
    assign pop      = ir_valid && ir_ready;
    assign push     = inflight_q && !squash_q;

    assign ir = fifo_empty ? last_q[DataSize-1:0] : head[DataSize-1:0];
    assign PC = fifo_empty ? last_q[EntryW-1:DataSize] : head[EntryW-1:DataSize];

    ifetch_fifo #(
        .Width (EntryW),
        .Depth (QDepth)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push),
        .data_i  ({resp_addr_q, instruction}),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            fetch_addr_q <= '0;
            resp_addr_q  <= '0;
            inflight_q   <= 1'b0;
            squash_q     <= 1'b0;
            last_q       <= '0;
        end else begin
            inflight_q  <= IM_read;
            resp_addr_q <= fetch_addr_q;
            // A read issued in the redirect cycle returns during FLUSH: drop it.
            squash_q    <= redirect_valid;
            if (!fifo_empty) last_q <= head;
            if (redirect_valid) begin
                state_q      <= StFlush;
                fetch_addr_q <= redirect_pc;
            end else begin
                if (IM_read) fetch_addr_q <= fetch_addr_q + MemSize'(1);
                unique case (state_q)
                    StIdle:  state_q <= StFetch;
                    StFetch: if (!has_space && !pop) state_q <= StFull;
                    StFull:  if (pop) state_q <= StFetch;
                    StFlush: state_q <= StFetch;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef IFETCH_PERF_EN
    logic [15:0] stall_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count_q <= '0;
        end else if ((state_q != StIdle) && !ir_valid && (stall_count_q != 16'hFFFF)) begin
            stall_count_q <= stall_count_q + 16'd1;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with an IM model returning address + 0x100.
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        IM_read, IM_write, IM_enable;
    logic [9:0]  IM_address;
    logic [31:0] instruction;
    logic        ir_valid;
    logic [31:0] ir;
    logic [9:0]  PC;
    logic        ir_ready;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
`ifdef IFETCH_PERF_EN
    logic [15:0] stall_count;
    logic [15:0] stall_base;
`endif

    int checks   = 0;
    int failures = 0;
    int reads;

    always #5 clk = ~clk;

    // Instruction memory: data for the address read in cycle N appears in N+1.
    always @(posedge clk) begin
        instruction <= IM_read ? (32'(IM_address) + 32'h100) : 32'hDEAD_BEEF;
    end

    ifetch_queue dut (
`ifdef IFETCH_PERF_EN
        .stall_count    (stall_count),
`endif
        .clk            (clk),
        .reset          (reset),
        .IM_read        (IM_read),
        .IM_write       (IM_write),
        .IM_enable      (IM_enable),
        .IM_address     (IM_address),
        .instruction    (instruction),
        .ir_valid       (ir_valid),
        .ir             (ir),
        .PC             (PC),
        .ir_ready       (ir_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset          = 1'b0;
        ir_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        step();
        step();
        check("rst_im_read", IM_read, 0);
        check("rst_im_enable", IM_enable, 0);
        check("rst_im_write", IM_write, 0);
        check("rst_im_address", IM_address, 0);
        check("rst_ir_valid", ir_valid, 0);
        check("rst_ir", ir, 0);
        check("rst_pc", PC, 0);

        // Streaming with decoder always ready.
        ir_ready = 1'b1;
        reset    = 1'b1;
        step();  // cycle 1: first FETCH cycle
        check("c1_im_read", IM_read, 1);
        check("c1_im_enable", IM_enable, 1);
        check("c1_im_address", IM_address, 0);
        check("c1_ir_valid", ir_valid, 0);
        step();
        check("c2_im_address", IM_address, 1);
        check("c2_ir_valid", ir_valid, 0);
        step();
        check("c3_ir_valid", ir_valid, 1);
        check("c3_ir", ir, 32'h100);
        check("c3_pc", PC, 0);
        step();
        check("c4_ir", ir, 32'h101);
        check("c4_pc", PC, 1);
        step();
        check("c5_ir", ir, 32'h102);
        check("c5_pc", PC, 2);

        // Back-pressure: queue fills, FSM parks in FULL.
        reset    = 1'b0;
        ir_ready = 1'b0;
        step();
        reset = 1'b1;
        reads = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (IM_read === 1'b1) reads++;
        end
        check("full_read_count", reads, 4);
        check("full_im_read", IM_read, 0);
        check("full_head_pc", PC, 0);
        check("full_head_ir", ir, 32'h100);
        ir_ready = 1'b1;
        step();
        check("resume_pc", PC, 1);
        check("resume_im_read", IM_read, 1);
        check("resume_im_address", IM_address, 4);
        step();
        check("drain_pc2", PC, 2);
        step();
        check("drain_pc3", PC, 3);
        step();
        check("drain_pc4", PC, 4);

        // Mid-stream reset with three entries queued.
        reset    = 1'b0;
        ir_ready = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("pre_rst_ir_valid", ir_valid, 1);
        reset = 1'b0;
        #1;
        check("midrst_ir_valid", ir_valid, 0);
        check("midrst_im_read", IM_read, 0);
        check("midrst_im_address", IM_address, 0);
        check("midrst_pc", PC, 0);
        @(negedge clk);
        reset    = 1'b1;
        ir_ready = 1'b1;
        step();
        check("restart_im_read", IM_read, 1);
        check("restart_im_address", IM_address, 0);
        step();
        step();
        check("restart_ir", ir, 32'h100);
        check("restart_pc", PC, 0);

        // Redirect while the read of 5 is outstanding.
        step();
        step();
        step();  // cycle 6
        check("redir_pre_address", IM_address, 5);
        redirect_valid = 1'b1;
        redirect_pc    = 10'h2A;
        step();  // FLUSH
        redirect_valid = 1'b0;
        check("flush_im_read", IM_read, 0);
        check("flush_ir_valid", ir_valid, 0);
        check("flush_im_address", IM_address, 10'h2A);
        step();
        check("redir_im_read", IM_read, 1);
        check("redir_im_address", IM_address, 10'h2A);
        check("redir_c8_ir_valid", ir_valid, 0);
        step();
        check("redir_c9_ir_valid", ir_valid, 0);
        step();
        check("redir_ir_valid", ir_valid, 1);
        check("redir_pc", PC, 10'h2A);
        check("redir_ir", ir, 32'h12A);

        // Redirect near the top of the address space: fetch wraps to 0.
        redirect_valid = 1'b1;
        redirect_pc    = 10'h3FE;
        step();
        redirect_valid = 1'b0;
        check("wrap_flush_ir_valid", ir_valid, 0);
        check("hold_ir", ir, 32'h12A);
        check("hold_pc", PC, 10'h2A);
        step();
        check("wrap_first_address", IM_address, 10'h3FE);
        step();
        step();
        check("wrap_im_address", IM_address, 0);
        check("wrap_pc0", PC, 10'h3FE);
        check("wrap_ir0", ir, 32'h4FE);
        step();
        check("wrap_pc1", PC, 10'h3FF);
        step();
        check("wrap_pc2", PC, 10'h000);
        check("wrap_ir2", ir, 32'h100);
        step();
        check("wrap_pc3", PC, 10'h001);
        check("wrap_valid3", ir_valid, 1);

`ifdef IFETCH_PERF_EN
        // Repeated redirects keep the queue empty for five counted cycles.
        redirect_valid = 1'b1;
        redirect_pc    = 10'h10;
        step();
        stall_base = stall_count;
        for (int i = 0; i < 5; i++) step();
        check("stall_count_delta", 32'(stall_count - stall_base), 5);
        redirect_valid = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DataSize, default 32, instruction word width.
REQ-002 SHALL have parameter MemSize, default 10, PC / IM address width (word address).
REQ-003 SHALL have parameter QDepth, default 4, prefetch queue entries (power of two, >=2).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 IM_read  output  1  IM read strobe.
REQ-007 IM_write  output  1  IM write strobe, tied 0.
REQ-008 IM_enable  output  1  IM chip enable, equal to IM_read.
REQ-009 IM_address  output  MemSize  IM word address.
REQ-010 instruction  input  DataSize  IM read data, valid exactly 1 cycle after IM_read.
REQ-011 ir_valid  output  1  queue head holds an instruction.
REQ-012 ir  output  DataSize  head instruction to decoder.
REQ-013 PC  output  MemSize  address of head instruction.
REQ-014 ir_ready  input  1  decoder accepts head; pop when ir_valid && ir_ready.
REQ-015 redirect_valid  input  1  branch/jump redirect request.
REQ-016 redirect_pc  input  MemSize  redirect target.

Function
REQ-017 FSM states: IDLE (after reset), FETCH (issuing), FULL (no space), FLUSH (one-cycle squash after redirect).
REQ-018 IDLE -> FETCH unconditionally on the first clock after reset release; first IM_read with IM_address=0 in that FETCH cycle.
REQ-019 In FETCH, IM_read=1 iff occupancy + in-flight < QDepth; otherwise go to FULL with IM_read=0.
REQ-020 FULL -> FETCH the cycle after a pop frees space; no read issued in the FULL cycle.
REQ-021 Response in cycle N+1 for a read in cycle N SHALL be pushed with its issue address; fetch address increments by 1 per issued read.
REQ-022 Fetch address SHALL wrap 2^MemSize-1 -> 0 with no flag.
REQ-023 Push and pop in same cycle SHALL both take effect; occupancy unchanged.
REQ-024 Pop on empty queue SHALL be ignored; ir_valid=0 whenever empty; ir and PC hold last value when empty.
REQ-025 Empty queue plus arriving response SHALL NOT bypass; ir_valid rises the cycle after the push.
REQ-026 redirect_valid SHALL in the same edge clear the queue, mark any in-flight response squashed, load fetch address := redirect_pc, enter FLUSH; overrides concurrent push, pop and issue.
REQ-027 In FLUSH, IM_read=0, squashed response discarded; next cycle FETCH issues redirect_pc.
REQ-028 redirect_valid during FLUSH SHALL restart FLUSH with the newer target.
REQ-029 Redirect and ir_ready in same cycle: head is consumed by decoder, then queue cleared.

Reset
REQ-030 On reset low: state IDLE, IM_read=0, IM_enable=0, IM_write=0, IM_address=0, ir_valid=0, ir=0, PC=0, occupancy 0, in-flight cleared, fetch address 0.
REQ-031 Reset assertion mid-operation SHALL discard queue and in-flight response immediately.

Configuration
REQ-032 Macro IFETCH_PERF_EN: when defined, adds output stall_count (16-bit) counting cycles with ir_valid=0 outside IDLE, saturating at 16'hFFFF, cleared by reset only.
REQ-033 Without IFETCH_PERF_EN: no stall_count port, no counter logic.

Structure
REQ-034 Package ifetch_pkg SHALL hold DataSize/MemSize/QDepth defaults and the FSM state encoding.
REQ-035 Queue storage and pointers SHALL be a sub-module ifetch_fifo (push, pop, flush, full, empty, count); FSM and address logic stay in ifetch_queue.

Verification
REQ-036 Reset release, ir_ready=1, IM returns addr+0x100 -> IM_address 0,1,2,...; ir=0x100 with PC=0 two cycles after first IM_read, then one per cycle.
REQ-037 ir_ready=0 for 10 cycles -> exactly 4 reads issued, state FULL, IM_read=0; ir_ready=1 -> pops 0..3 in order, fetch resumes at address 4.
REQ-038 Redirect to 0x2A while read of 5 in flight -> instruction for 5 never appears; next ir has PC=0x2A.
REQ-039 Redirect to 0x3FE -> PCs 0x3FE, 0x3FF, 0x000, 0x001 delivered.
REQ-040 Assert reset mid-stream with 3 entries queued -> ir_valid=0, IM_read=0 immediately; restart fetches from 0.
REQ-041 With IFETCH_PERF_EN, hold IM data path stalled by repeated redirects for 5 cycles -> stall_count increments by 5.
